// File: rtl/iob_plic_gateway_arb.sv
// PLIC interrupt core: per-source edge/level gateways with saturating pending counters
// feeding N_TARGETS registered priority arbiters. Define IOB_PLIC_THRESHOLD_EN to enable per-target thresholds.
module iob_plic_gateway_arb #(
    parameter int unsigned N_SOURCES         = 31,
    parameter int unsigned N_TARGETS         = 2,
    parameter int unsigned PRIORITIES        = 8,
    parameter int unsigned MAX_PENDING_COUNT = 4,
    localparam int unsigned PRIO_W           = $clog2(PRIORITIES),
    localparam int unsigned SRC_W            = $clog2(N_SOURCES + 1),
    localparam int unsigned CNT_W            = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic                             cke_i,
    input  logic [N_SOURCES-1:0]             src_i,
    input  logic [N_SOURCES-1:0]             el_i,
    input  logic [N_SOURCES*PRIO_W-1:0]      prio_i,
    input  logic [N_TARGETS*N_SOURCES-1:0]   ie_i,
    input  logic [N_TARGETS*PRIO_W-1:0]      th_i,
    input  logic [N_TARGETS-1:0]             claim_i,
    input  logic [N_TARGETS-1:0]             complete_i,
    input  logic [N_TARGETS*SRC_W-1:0]       cmpl_id_i,
    output logic [N_SOURCES-1:0]             ip_o,
    output logic [N_TARGETS*SRC_W-1:0]       id_o,
    output logic [N_TARGETS-1:0]             irq_o
);

    logic [N_SOURCES-1:0]              ip_q, ip_d;
    logic [N_SOURCES-1:0]              busy_q, busy_d;
    logic [N_SOURCES-1:0]              src_d_q, src_d_d;
    logic [N_SOURCES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_TARGETS-1:0][SRC_W-1:0]   id_q, id_d;
    logic [N_TARGETS-1:0]              irq_q, irq_d;

    logic [N_SOURCES-1:0]              claim_mask;
    logic [N_SOURCES-1:0]              cmpl_mask;
    logic [N_SOURCES-1:0]              edge_ev;
    logic [N_SOURCES-1:0]              take;
    logic [N_TARGETS-1:0][N_SOURCES-1:0] cand;
    logic [N_TARGETS-1:0][PRIO_W-1:0]  best_prio;

`ifndef IOB_PLIC_THRESHOLD_EN
    logic th_unused;
    assign th_unused = ^th_i;
`endif

    // Decode claim/complete pulses into per-source masks; a shared claim collapses to one owner.
    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int unsigned t = 0; t < N_TARGETS; t++) begin
            for (int unsigned s = 0; s < N_SOURCES; s++) begin
                if (claim_i[t] && id_q[t] == SRC_W'(s + 1))
                    claim_mask[s] = 1'b1;
                if (complete_i[t] && cmpl_id_i[t*SRC_W +: SRC_W] == SRC_W'(s + 1))
                    cmpl_mask[s] = 1'b1;
            end
        end
    end

    always_comb begin
        ip_d    = ip_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        src_d_d = src_i;
        edge_ev = '0;
        take    = '0;
        for (int unsigned s = 0; s < N_SOURCES; s++) begin
            edge_ev[s] = el_i[s] & src_i[s] & ~src_d_q[s];
            take[s]    = ~busy_q[s] & ~ip_q[s] &
                         (el_i[s] ? (cnt_q[s] != '0) : src_i[s]);
            if (take[s]) begin
                ip_d[s] = 1'b1;
                if (el_i[s])
                    cnt_d[s] = cnt_q[s] - CNT_W'(1);
            end
            // Decrement first so an event coinciding with a take nets out even at saturation.
            if (edge_ev[s] && cnt_d[s] < CNT_W'(MAX_PENDING_COUNT))
                cnt_d[s] = cnt_d[s] + CNT_W'(1);
            if (cmpl_mask[s] && busy_q[s])
                busy_d[s] = 1'b0;
            if (claim_mask[s]) begin
                ip_d[s]   = 1'b0;
                busy_d[s] = 1'b1;
            end
        end
    end

    // Sources claimed this cycle are masked so the next id_o already excludes them.
    always_comb begin
        cand = '0;
        for (int unsigned t = 0; t < N_TARGETS; t++) begin
            for (int unsigned s = 0; s < N_SOURCES; s++) begin
                cand[t][s] = ip_q[s] & ~claim_mask[s] & ie_i[t*N_SOURCES + s] &
                             (prio_i[s*PRIO_W +: PRIO_W] != '0)
`ifdef IOB_PLIC_THRESHOLD_EN
                             & (prio_i[s*PRIO_W +: PRIO_W] > th_i[t*PRIO_W +: PRIO_W])
`endif
                             ;
            end
        end
    end

    always_comb begin
        id_d      = '0;
        irq_d     = '0;
        best_prio = '0;
        for (int unsigned t = 0; t < N_TARGETS; t++) begin
            for (int unsigned s = 0; s < N_SOURCES; s++) begin
                if (cand[t][s] && prio_i[s*PRIO_W +: PRIO_W] > best_prio[t]) begin
                    best_prio[t] = prio_i[s*PRIO_W +: PRIO_W];
                    id_d[t]      = SRC_W'(s + 1);
                end
            end
            irq_d[t] = (id_d[t] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ip_q    <= '0;
            busy_q  <= '0;
            src_d_q <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            irq_q   <= '0;
        end else if (cke_i) begin
            ip_q    <= ip_d;
            busy_q  <= busy_d;
            src_d_q <= src_d_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            irq_q   <= irq_d;
        end
    end

    assign ip_o  = ip_q;
    assign id_o  = id_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_iob_plic_gateway_arb.sv
// Scoreboard bench for iob_plic_gateway_arb: stimulus queues expected outputs, a negedge monitor compares.
module tb_iob_plic_gateway_arb;

    localparam int NS = 31;
    localparam int NT = 2;
    localparam int PW = 3;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              cke;
    logic [NS-1:0]     src, el;
    logic [NS*PW-1:0]  prio;
    logic [NT*NS-1:0]  ie;
    logic [NT*PW-1:0]  th;
    logic [NT-1:0]     claim, complete;
    logic [NT*SW-1:0]  cmpl_id;
    logic [NS-1:0]     ip;
    logic [NT*SW-1:0]  id;
    logic [NT-1:0]     irq;

    always #5 clk = ~clk;

    iob_plic_gateway_arb #(
        .N_SOURCES(31), .N_TARGETS(2), .PRIORITIES(8), .MAX_PENDING_COUNT(4)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .src_i(src), .el_i(el),
        .prio_i(prio), .ie_i(ie), .th_i(th), .claim_i(claim), .complete_i(complete),
        .cmpl_id_i(cmpl_id), .ip_o(ip), .id_o(id), .irq_o(irq)
    );

    // kind: 0 = ip bit, 1 = id of target, 2 = irq of target, 3 = whole ip vector
    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = {31'b0, ip[e.idx]};
                1:       act = 32'(id[e.idx*SW +: SW]);
                2:       act = {31'b0, irq[e.idx]};
                default: act = {1'b0, ip};
            endcase
            nvec++;
            if (act !== e.exp) begin
                nmis++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string n, input int k, input int i, input int v);
        exp_t e;
        e.name = n; e.kind = k; e.idx = i; e.exp = 32'(v);
        sb.push_back(e);
    endtask
    task automatic chk_ip(input string n, input int s, input int v);  push(n, 0, s - 1, v); endtask
    task automatic chk_id(input string n, input int t, input int v);  push(n, 1, t, v);     endtask
    task automatic chk_irq(input string n, input int t, input int v); push(n, 2, t, v);     endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_prio(input int s, input int p);
        prio[(s-1)*PW +: PW] = PW'(p);
    endtask
    task automatic set_ie(input int t, input int s, input logic v);
        ie[t*NS + s - 1] = v;
    endtask
    task automatic do_claim(input int t);
        claim[t] = 1'b1;
        tick();
        claim = '0;
    endtask
    task automatic do_complete(input int t, input int s);
        complete[t] = 1'b1;
        cmpl_id[t*SW +: SW] = SW'(s);
        tick();
        complete = '0;
        cmpl_id  = '0;
    endtask
    task automatic pulse(input int s);
        src[s-1] = 1'b1;
        tick();
        src[s-1] = 1'b0;
        tick();
    endtask

    initial begin
        arst_n = 1'b0; cke = 1'b1;
        src = '1; el = '0; prio = '0; ie = '0; th = '0;
        claim = '0; complete = '0; cmpl_id = '0;

        // 1: reset holds everything clear even with all sources asserted
        tick(); tick();
        push("rst_ip", 3, 0, 0);
        chk_id("rst_id0", 0, 0); chk_id("rst_id1", 1, 0);
        chk_irq("rst_irq0", 0, 0); chk_irq("rst_irq1", 1, 0);
        tick();
        src = '0;
        arst_n = 1'b1;
        tick();

        // 2: level source 3
        set_prio(3, 2); set_ie(0, 3, 1'b1);
        src[2] = 1'b1;
        tick();
        chk_ip("lvl_ip_k1", 3, 1); chk_irq("lvl_irq_k1", 0, 0);
        tick();
        chk_irq("lvl_irq_k2", 0, 1); chk_id("lvl_id_k2", 0, 3);
        do_claim(0);
        chk_ip("lvl_ip_claim", 3, 0); chk_irq("lvl_irq_claim", 0, 0);
        do_complete(0, 3);
        chk_ip("lvl_ip_cmpl", 3, 0);
        tick();
        chk_ip("lvl_ip_reset", 3, 1);
        tick();
        chk_irq("lvl_irq_again", 0, 1); chk_id("lvl_id_again", 0, 3);
        do_claim(0);
        src[2] = 1'b0;
        do_complete(0, 3);
        set_prio(3, 0); set_ie(0, 3, 1'b0);
        tick();

        // 3: edge source 5, queue saturates at 4
        el[4] = 1'b1; set_prio(5, 3); set_ie(0, 5, 1'b1);
        pulse(5);
        chk_ip("edg_ip", 5, 1);
        tick();
        chk_irq("edg_irq", 0, 1); chk_id("edg_id", 0, 5);
        do_claim(0);
        for (int i = 0; i < 6; i++) pulse(5);
        chk_ip("edg_busy_ip", 5, 0); chk_irq("edg_busy_irq", 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_complete(0, 5);
            tick(); tick();
            chk_irq($sformatf("edg_q%0d_irq", i), 0, 1);
            chk_id($sformatf("edg_q%0d_id", i), 0, 5);
            do_claim(0);
            chk_id($sformatf("edg_q%0d_clm", i), 0, 0);
        end
        do_complete(0, 5);
        tick(); tick();
        chk_id("edg_empty_id", 0, 0); chk_irq("edg_empty_irq", 0, 0);
        do_claim(0);
        chk_ip("edg_5th_ip", 5, 0); chk_id("edg_5th_id", 0, 0);
        el[4] = 1'b0; set_prio(5, 0); set_ie(0, 5, 1'b0);

        // 4: arbitration, max priority then lowest ID
        set_prio(2, 3); set_prio(7, 5); set_prio(9, 5);
        set_ie(0, 2, 1'b1); set_ie(0, 7, 1'b1); set_ie(0, 9, 1'b1);
        src[1] = 1'b1; src[6] = 1'b1; src[8] = 1'b1;
        tick(); tick();
        chk_id("arb_first", 0, 7);
        do_claim(0);
        chk_id("arb_second", 0, 9);
        do_claim(0);
        chk_id("arb_third", 0, 2);
        do_claim(0);
        chk_id("arb_none", 0, 0); chk_irq("arb_none_irq", 0, 0);
        src = '0;
        do_complete(0, 2); do_complete(0, 7); do_complete(0, 9);
        prio = '0; ie = '0;

        // 5: same source claimed by both targets
        set_prio(4, 4); set_prio(6, 2);
        set_ie(0, 4, 1'b1); set_ie(1, 4, 1'b1); set_ie(1, 6, 1'b1);
        src[3] = 1'b1; src[5] = 1'b1;
        tick(); tick();
        chk_id("two_id0", 0, 4); chk_id("two_id1", 1, 4);
        claim = 2'b11;
        tick();
        claim = '0;
        chk_ip("two_ip4", 4, 0);
        chk_id("two_id0_after", 0, 0); chk_id("two_id1_after", 1, 6);
        src = '0;
        do_claim(1);
        complete = 2'b11;
        cmpl_id = {SW'(6), SW'(4)};
        tick();
        complete = '0; cmpl_id = '0;
        tick(); tick();
        push("two_clean_ip", 3, 0, 0);
        chk_irq("two_clean_irq1", 1, 0);
        prio = '0; ie = '0;

        // 6: threshold, clock enable and ignored completes
        th[0 +: PW] = 3'd4;
        set_prio(1, 4); set_ie(0, 1, 1'b1);
        src[0] = 1'b1;
        tick(); tick();
`ifdef IOB_PLIC_THRESHOLD_EN
        chk_irq("th_p4_irq", 0, 0); chk_id("th_p4_id", 0, 0);
`else
        chk_irq("th_p4_irq", 0, 1); chk_id("th_p4_id", 0, 1);
`endif
        set_prio(1, 5);
        tick();
        chk_irq("th_p5_irq", 0, 1); chk_id("th_p5_id", 0, 1);
        cke = 1'b0;
        do_claim(0);
        cke = 1'b1;
        chk_ip("cke_ip", 1, 1); chk_id("cke_id", 0, 1);
        do_complete(0, 0);
        chk_ip("cmpl0_ip", 1, 1); chk_irq("cmpl0_irq", 0, 1);
        do_complete(0, 1);
        chk_ip("cmplnb_ip", 1, 1); chk_id("cmplnb_id", 0, 1);
        do_claim(0);
        chk_ip("claim1_ip", 1, 0); chk_irq("claim1_irq", 0, 0);
        src = '0;
        do_complete(0, 1);
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            nvec++; nmis++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
